// File: rtl/arb_merge_pkg.sv
// Shared constants and the rotating first-set search used by the arb_merge_rr arbiter.
package arb_merge_pkg;

    localparam int ARB_RR    = 0;
    localparam int ARB_FIXED = 1;
    localparam int MAX_CH    = 64;

    // First set bit of req, scanning ptr, ptr+1, ... modulo n; returns 0 if none is set.
    function automatic int rr_first(input logic [MAX_CH-1:0] req, input int ptr, input int n);
        int   k;
        logic found;
        rr_first = 0;
        found    = 1'b0;
        for (int i = 0; i < MAX_CH; i++) begin
            if (i < n && !found) begin
                k = ptr + i;
                if (k >= n) k = k - n;
                if (req[k]) begin
                    rr_first = k;
                    found    = 1'b1;
                end
            end
        end
    endfunction

endpackage

// File: rtl/arb_merge_rr_in_fifo.sv
// Per-channel synchronous FIFO; head entry is visible on dout without a read cycle.
module arb_in_fifo
    import arb_merge_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int FIFO_DEPTH = 2,
    localparam int AW        = $clog2(FIFO_DEPTH),
    localparam int CW        = $clog2(FIFO_DEPTH) + 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  push,
    input  logic                  pop,
    input  logic [DATA_WIDTH-1:0] din,
    output logic [DATA_WIDTH-1:0] dout,
    output logic [CW-1:0]         count,
    output logic                  full,
    output logic                  empty
);

    logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
    logic [AW-1:0]         wr_ptr;
    logic [AW-1:0]         rd_ptr;
    logic                  push_en;
    logic                  pop_en;

    assign full    = (count == CW'(FIFO_DEPTH));
    assign empty   = (count == '0);
    // A full FIFO refuses a push even when it is popped in the same cycle.
    assign push_en = push & ~full;
    assign pop_en  = pop & ~empty;
    assign dout    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (push_en) mem[wr_ptr] <= din;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_en) wr_ptr <= wr_ptr + 1'b1;
            if (pop_en)  rd_ptr <= rd_ptr + 1'b1;
            case ({push_en, pop_en})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/arb_merge_rr.sv
// N-to-1 arbitrating merge: per-channel FIFOs, round-robin or fixed-priority pick,
// and a registered output stage tagged with the source channel index.
module arb_merge_rr
    import arb_merge_pkg::*;
#(
    parameter int NUM_CH     = 8,
    parameter int DATA_WIDTH = 8,
    parameter int FIFO_DEPTH = 2,
    parameter int ARB_MODE   = 0,
    localparam int ID_W      = $clog2(NUM_CH)
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [NUM_CH-1:0]            i_drive,
    input  logic [NUM_CH*DATA_WIDTH-1:0] i_data,
    output logic [NUM_CH-1:0]            o_free,
    output logic                         o_driveNext,
    output logic [DATA_WIDTH-1:0]        o_data,
    output logic [ID_W-1:0]              o_src_id,
    input  logic                         i_freeNext
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    logic [NUM_CH-1:0]     req;
    logic [NUM_CH-1:0]     full;
    logic [NUM_CH-1:0]     empty;
    logic [NUM_CH-1:0]     push;
    logic [NUM_CH-1:0]     pop;
    logic [DATA_WIDTH-1:0] head [NUM_CH];
    logic [CW-1:0]         cnt  [NUM_CH];

    logic [MAX_CH-1:0]     req_ext;
    logic [ID_W-1:0]       win;
    logic [ID_W-1:0]       ptr_nxt;
    logic                  load;

    logic                  vld_p1;
    logic [DATA_WIDTH-1:0] data_p1;
    logic [ID_W-1:0]       src_p1;
    logic [ID_W-1:0]       rr_ptr;

    for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
        assign o_free[k] = (cnt[k] != CW'(FIFO_DEPTH));
        assign req[k]    = ~empty[k];
        assign push[k]   = i_drive[k] & ~full[k];
        assign pop[k]    = load & (win == ID_W'(k));

        arb_in_fifo #(
            .DATA_WIDTH (DATA_WIDTH),
            .FIFO_DEPTH (FIFO_DEPTH)
        ) u_fifo (
            .clk   (clk),
            .rst   (rst),
            .push  (push[k]),
            .pop   (pop[k]),
            .din   (i_data[k*DATA_WIDTH +: DATA_WIDTH]),
            .dout  (head[k]),
            .count (cnt[k]),
            .full  (full[k]),
            .empty (empty[k])
        );
    end

    // Stage p0: pick a winner from the registered FIFO occupancy
    always_comb begin
        req_ext             = '0;
        req_ext[NUM_CH-1:0] = req;
        if (ARB_MODE == ARB_RR)
            win = ID_W'(rr_first(req_ext, int'(rr_ptr), NUM_CH));
        else
            win = ID_W'(rr_first(req_ext, 0, NUM_CH));
        ptr_nxt = (win == ID_W'(NUM_CH - 1)) ? '0 : win + 1'b1;
    end

    assign load = (~vld_p1 | i_freeNext) & (|req);

    // Stage p1: output register, held while downstream stalls
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_p1  <= 1'b0;
            data_p1 <= '0;
            src_p1  <= '0;
            rr_ptr  <= '0;
        end else if (load) begin
            vld_p1  <= 1'b1;
            data_p1 <= head[win];
            src_p1  <= win;
            if (ARB_MODE == ARB_RR) rr_ptr <= ptr_nxt;
        end else if (i_freeNext) begin
            vld_p1  <= 1'b0;
        end
    end

    assign o_driveNext = vld_p1;
    assign o_data      = data_p1;
    assign o_src_id    = src_p1;

endmodule
